mru_tracker: RTL and testbench

Parametrised recency tracker for N_CH slot buttons driving per-slot "free" LEDs. It replaces the fixed five-button, timestamp-based tracker with a rank-based recency stack, a selectable eviction policy and eviction reporting. Buttons are sampled on a prescaled tick. When every slot is occupied, one slot is evicted according to POLICY. It sits between the board button synchronisers and the LED drivers.

---
 rtl/mru_pkg.sv | 19 +
 rtl/mru_prescaler.sv | 36 +++
 rtl/mru_tracker_chk.sv | 16 +
 rtl/mru_tracker.sv | 161 ++++++++++++++++
 tb/tb_mru_tracker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mru_pkg.sv
// Shared types and helpers for the MRU/LRU recency tracker.
package mru_pkg;

    typedef enum logic {
        POLICY_MRU = 1'b0,
        POLICY_LRU = 1'b1
    } policy_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    function automatic int mru_rank_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mru_prescaler.sv
// Terminal-count divider: tick is high for the one cycle the counter sits at TICK_DIV-1.
module mru_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM    = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // Count up, wrapping to zero after the terminal count.
    always_comb begin
        if (tick) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mru_tracker_chk.sv
// Simulation-only check: a sample tick must never land while the FSM is busy.
module mru_tracker_chk (
    input logic clk,
    input logic rst,
    input logic tick,
    input logic idle
);

    // Flag a tick arriving outside IDLE (TICK_DIV too small).
    always_ff @(posedge clk) begin
        if (!rst && tick) begin
            assert (idle);
        end
    end

endmodule

// File: rtl/mru_tracker.sv
// Rank-based recency tracker: one button access per tick, eviction by policy when full,
// per-slot "free" LEDs and a one-cycle eviction report.
module mru_tracker
    import mru_pkg::*;
#(
    parameter int      N_CH     = 5,
    parameter int      TICK_DIV = 100_000_000,
    parameter policy_t POLICY   = POLICY_MRU
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         btn,
    output logic [N_CH-1:0]         led,
    output logic                    full,
    output logic [$clog2(N_CH)-1:0] mru_idx,
    output logic                    evict_valid,
    output logic [$clog2(N_CH)-1:0] evict_idx
);
    localparam int RW = mru_rank_w(N_CH);
    localparam int CW = $clog2(N_CH + 1);
    localparam logic [RW-1:0] RANK_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] RANK_ONE    = RW'(1);
    localparam logic [RW-1:0] RANK_LAST   = RW'(N_CH - 1);
    localparam logic [RW-1:0] VICTIM_RANK = (POLICY == POLICY_MRU) ? RANK_ZERO : RANK_LAST;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(N_CH);

    state_t          state_q, state_d;
    logic [N_CH-1:0] valid_q, valid_d;
    logic [RW-1:0]   rank_q [N_CH];
    logic [RW-1:0]   rank_d [N_CH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_vld_q, acc_vld_d;
    logic [RW-1:0]   acc_idx_q, acc_idx_d;
    logic            evict_valid_q, evict_valid_d;
    logic [RW-1:0]   evict_idx_q, evict_idx_d;

    logic            tick_s;
    logic [RW-1:0]   hit_rank_s;
    logic [RW-1:0]   victim_s;
    logic [RW-1:0]   mru_s;

    mru_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    mru_tracker_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s),
        .idle (state_q == IDLE)
    );

    // Victim is the slot holding the policy rank; MRU slot is the one holding rank 0.
    always_comb begin
        hit_rank_s = rank_q[acc_idx_q];
        victim_s   = RANK_ZERO;
        mru_s      = RANK_ZERO;
        for (int i = 0; i < N_CH; i++) begin
            victim_s = (valid_q[i] && (rank_q[i] == VICTIM_RANK)) ? RW'(i) : victim_s;
            mru_s    = (valid_q[i] && (rank_q[i] == RANK_ZERO))   ? RW'(i) : mru_s;
        end
    end

    // FSM next state plus rank/valid/count updates.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        rank_d        = rank_q;
        cnt_d         = cnt_q;
        acc_vld_d     = acc_vld_q;
        acc_idx_d     = acc_idx_q;
        evict_valid_d = 1'b0;
        evict_idx_d   = evict_idx_q;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d   = UPDATE;
                    acc_vld_d = |btn;
                    acc_idx_d = RANK_ZERO;
                    // Walk downwards so the lowest pressed index wins.
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        acc_idx_d = btn[i] ? RW'(i) : acc_idx_d;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                state_d = CHECK;
                if (acc_vld_q) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (valid_q[i] && (!valid_q[acc_idx_q] || (rank_q[i] < hit_rank_s))) begin
                            rank_d[i] = rank_q[i] + RANK_ONE;
                        end else begin
                            rank_d[i] = rank_q[i];
                        end
                    end
                    rank_d[acc_idx_q]  = RANK_ZERO;
                    valid_d[acc_idx_q] = 1'b1;
                    cnt_d = valid_q[acc_idx_q] ? cnt_q : (cnt_q + CNT_ONE);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (cnt_q == CNT_FULL) begin
                    // Dropping rank 0 shifts every survivor up one place under MRU.
                    for (int i = 0; i < N_CH; i++) begin
                        rank_d[i] = (POLICY == POLICY_MRU) ? (rank_q[i] - RANK_ONE) : rank_q[i];
                    end
                    rank_d[victim_s]  = RANK_ZERO;
                    valid_d[victim_s] = 1'b0;
                    cnt_d             = cnt_q - CNT_ONE;
                    evict_valid_d     = 1'b1;
                    evict_idx_d       = victim_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any pending access or eviction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= {N_CH{1'b0}};
            cnt_q         <= {CW{1'b0}};
            acc_vld_q     <= 1'b0;
            acc_idx_q     <= RANK_ZERO;
            evict_valid_q <= 1'b0;
            evict_idx_q   <= RANK_ZERO;
            for (int i = 0; i < N_CH; i++) begin
                rank_q[i] <= RANK_ZERO;
            end
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
            acc_vld_q     <= acc_vld_d;
            acc_idx_q     <= acc_idx_d;
            evict_valid_q <= evict_valid_d;
            evict_idx_q   <= evict_idx_d;
            rank_q        <= rank_d;
        end
    end

    assign led         = ~valid_q;
    assign full        = (cnt_q == CNT_FULL);
    assign mru_idx     = mru_s;
    assign evict_valid = evict_valid_q;
    assign evict_idx   = evict_idx_q;

endmodule

// File: tb/tb_mru_tracker.sv
// Table-driven bench for mru_tracker (N_CH=5, TICK_DIV=4), MRU and LRU instances in parallel.
module tb_mru_tracker;
    import mru_pkg::*;

    typedef struct packed {
        logic [4:0] pre_led;
        logic [2:0] pre_mru;
        logic [4:0] post_led;
        logic [2:0] post_mru;
        logic       ev;
        logic [2:0] evidx;
    } dexp_t;

    typedef struct packed {
        logic [4:0] btn;
        dexp_t      m;
        dexp_t      l;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = 5'b00000;
    logic [4:0] led_m, led_l;
    logic       full_m, full_l, ev_m, ev_l;
    logic [2:0] mru_m, mru_l, eidx_m, eidx_l;

    vec_t sb[$];
    vec_t tab[9];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mru_tracker #(.N_CH(5), .TICK_DIV(4), .POLICY(POLICY_MRU)) dut_m (
        .clk(clk), .rst(rst), .btn(btn), .led(led_m), .full(full_m),
        .mru_idx(mru_m), .evict_valid(ev_m), .evict_idx(eidx_m)
    );

    mru_tracker #(.N_CH(5), .TICK_DIV(4), .POLICY(POLICY_LRU)) dut_l (
        .clk(clk), .rst(rst), .btn(btn), .led(led_l), .full(full_l),
        .mru_idx(mru_l), .evict_valid(ev_l), .evict_idx(eidx_l)
    );

    function automatic dexp_t mk(input logic [4:0] pl, input logic [2:0] pm,
                                 input logic [4:0] ql, input logic [2:0] qm,
                                 input logic ev, input logic [2:0] ei);
        return {pl, pm, ql, qm, ev, ei};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input dexp_t e, input bit post,
                             input logic [4:0] led, input logic full, input logic [2:0] mru,
                             input logic ev, input logic [2:0] eidx);
        logic [4:0] xl;
        logic [2:0] xm;
        logic       xe;
        xl = post ? e.post_led : e.pre_led;
        xm = post ? e.post_mru : e.pre_mru;
        xe = post ? e.ev : 1'b0;
        chk({tag, "_led"},  8'(led),  8'(xl));
        chk({tag, "_full"}, 8'(full), 8'(xl == 5'b00000));
        chk({tag, "_mru"},  8'(mru),  8'(xm));
        chk({tag, "_ev"},   8'(ev),   8'(xe));
        if (xe) chk({tag, "_eidx"}, 8'(eidx), 8'(e.evidx));
    endtask

    // One 4-cycle window: tick falls in cycle 3; the previous window's access is visible
    // in cycle 1 (T+2) and its eviction in cycle 2 (T+3).
    task automatic run_window(input vec_t v, input bit push);
        vec_t e;
        bit   have;
        btn  = v.btn;
        have = (sb.size() > 0);
        e    = '0;
        if (have) e = sb.pop_front();
        @(negedge clk);
        @(negedge clk);
        if (have) begin
            check_dut("pre_m", e.m, 1'b0, led_m, full_m, mru_m, ev_m, eidx_m);
            check_dut("pre_l", e.l, 1'b0, led_l, full_l, mru_l, ev_l, eidx_l);
        end
        @(negedge clk);
        if (have) begin
            check_dut("post_m", e.m, 1'b1, led_m, full_m, mru_m, ev_m, eidx_m);
            check_dut("post_l", e.l, 1'b1, led_l, full_l, mru_l, ev_l, eidx_l);
        end
        @(negedge clk);
        chk("ev_idle_m", 8'(ev_m), 8'h00);
        chk("ev_idle_l", 8'(ev_l), 8'h00);
        @(posedge clk);
        #1;
        if (push) sb.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_led_m"},  8'(led_m),  8'h1f);
        chk({tag, "_led_l"},  8'(led_l),  8'h1f);
        chk({tag, "_full_m"}, 8'(full_m), 8'h00);
        chk({tag, "_full_l"}, 8'(full_l), 8'h00);
        chk({tag, "_mru_m"},  8'(mru_m),  8'h00);
        chk({tag, "_mru_l"},  8'(mru_l),  8'h00);
        chk({tag, "_ev_m"},   8'(ev_m),   8'h00);
        chk({tag, "_ev_l"},   8'(ev_l),   8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 5'b00000;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        chk("rst_eidx_m", 8'(eidx_m), 8'h00);
        chk("rst_eidx_l", 8'(eidx_l), 8'h00);
        rst = 1'b0;
    endtask

    task automatic access(input logic [4:0] b, input dexp_t m, input dexp_t l);
        vec_t v;
        v.btn = b;
        v.m   = m;
        v.l   = l;
        run_window(v, 1'b1);
    endtask

    task automatic flush();
        vec_t v;
        v = '0;
        run_window(v, 1'b0);
    endtask

    initial begin
        tab[0] = '{5'b00001, mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0), mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0)};
        tab[1] = '{5'b00010, mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0), mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0)};
        tab[2] = '{5'b00100, mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0), mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0)};
        tab[3] = '{5'b00001, mk(5'b11000, 3'd0, 5'b11000, 3'd0, 1'b0, 3'd0), mk(5'b11000, 3'd0, 5'b11000, 3'd0, 1'b0, 3'd0)};
        tab[4] = '{5'b01000, mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0), mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0)};
        tab[5] = '{5'b10000, mk(5'b00000, 3'd4, 5'b10000, 3'd3, 1'b1, 3'd4), mk(5'b00000, 3'd4, 5'b00010, 3'd4, 1'b1, 3'd1)};
        tab[6] = '{5'b00000, mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0), mk(5'b00010, 3'd4, 5'b00010, 3'd4, 1'b0, 3'd0)};
        tab[7] = '{5'b00110, mk(5'b10000, 3'd1, 5'b10000, 3'd1, 1'b0, 3'd0), mk(5'b00000, 3'd1, 5'b00100, 3'd1, 1'b1, 3'd2)};
        tab[8] = '{5'b10000, mk(5'b00000, 3'd4, 5'b10000, 3'd1, 1'b1, 3'd4), mk(5'b00100, 3'd4, 5'b00100, 3'd4, 1'b0, 3'd0)};

        // Mixed hits, misses, idle tick and simultaneous presses.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_window(tab[i], 1'b1);
        end
        flush();

        // Fill slots 0..4 in order: MRU evicts slot 4, LRU evicts slot 0.
        do_reset();
        access(5'b00001, mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0), mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0));
        access(5'b00010, mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0), mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0));
        access(5'b00100, mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0), mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0));
        access(5'b01000, mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0), mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0));
        access(5'b10000, mk(5'b00000, 3'd4, 5'b10000, 3'd3, 1'b1, 3'd4), mk(5'b00000, 3'd4, 5'b00001, 3'd4, 1'b1, 3'd0));
        flush();

        // Two buttons held across one tick: only the lower index is taken.
        do_reset();
        access(5'b00110, mk(5'b11101, 3'd1, 5'b11101, 3'd1, 1'b0, 3'd0), mk(5'b11101, 3'd1, 5'b11101, 3'd1, 1'b0, 3'd0));
        flush();

        // Reset during UPDATE of the fifth access discards it and the eviction.
        do_reset();
        access(5'b00001, mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0), mk(5'b11110, 3'd0, 5'b11110, 3'd0, 1'b0, 3'd0));
        access(5'b00010, mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0), mk(5'b11100, 3'd1, 5'b11100, 3'd1, 1'b0, 3'd0));
        access(5'b00100, mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0), mk(5'b11000, 3'd2, 5'b11000, 3'd2, 1'b0, 3'd0));
        access(5'b01000, mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0), mk(5'b10000, 3'd3, 5'b10000, 3'd3, 1'b0, 3'd0));
        begin
            vec_t v;
            v     = '0;
            v.btn = 5'b10000;
            run_window(v, 1'b0);
        end
        rst = 1'b1;
        btn = 5'b00000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mid_rst_ev_m",  8'(ev_m),  8'h00);
            chk("mid_rst_ev_l",  8'(ev_l),  8'h00);
            chk("mid_rst_led_m", 8'(led_m), 8'h1f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
